// File: rtl/affinex_pkg.sv
// Shared definitions for the affine-transform bus initiator: register map,
// sequencing states and small data helpers.
package affinex_pkg;

    localparam logic [5:0] ADDR_CTRL = 6'h00;
    localparam logic [5:0] ADDR_STAT = 6'h04;
    localparam logic [5:0] ADDR_A    = 6'h08;
    localparam logic [5:0] ADDR_B    = 6'h0C;
    localparam logic [5:0] ADDR_D    = 6'h10;
    localparam logic [5:0] ADDR_E    = 6'h14;
    localparam logic [5:0] ADDR_TX   = 6'h18;
    localparam logic [5:0] ADDR_TY   = 6'h1C;
    localparam logic [5:0] ADDR_XIN  = 6'h20;
    localparam logic [5:0] ADDR_YIN  = 6'h24;
    localparam logic [5:0] ADDR_XOUT = 6'h28;
    localparam logic [5:0] ADDR_YOUT = 6'h2C;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        CFG  = 4'd1,
        WR_X = 4'd2,
        WR_Y = 4'd3,
        GO   = 4'd4,
        WAIT = 4'd5,
        STOP = 4'd6,
        POLL = 4'd7,
        RD_X = 4'd8,
        RD_Y = 4'd9,
        OUT  = 4'd10
    } host_state_t;

    // Peripheral registers are 32 bits wide; 16-bit values travel sign-extended.
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Coefficient registers A,B,D,E,TX,TY are consecutive words starting at A.
    function automatic logic [5:0] coef_addr(input logic [2:0] idx);
        return ADDR_A + {1'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/affinex_bus_access.sv
// Single-transaction bus engine: launches one read or write per request,
// holds strobe/address/data until the peripheral raises data_ready, then
// pulses done for one cycle with the captured read data.
module affinex_bus_access
    import affinex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [5:0]  address,
    output logic [31:0] bus_wdata,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        data_ready
);

    logic active;

    // Access engine: a request is ignored in the done cycle, so consecutive
    // accesses are always separated by at least one idle bus cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active       <= 1'b0;
            done         <= 1'b0;
            rdata        <= 32'h0000_0000;
            address      <= 6'h00;
            bus_wdata    <= 32'h0000_0000;
            data_write_n <= 2'b11;
            data_read_n  <= 2'b11;
        end else begin
            done <= 1'b0;
            if (active) begin
                if (data_ready) begin
                    active       <= 1'b0;
                    done         <= 1'b1;
                    data_write_n <= 2'b11;
                    data_read_n  <= 2'b11;
                    rdata        <= bus_rdata;
                end else begin
                    active <= 1'b1;
                end
            end else if (req && !done) begin
                active       <= 1'b1;
                address      <= addr;
                bus_wdata    <= wdata;
                data_write_n <= we ? 2'b10 : 2'b11;
                data_read_n  <= we ? 2'b11 : 2'b10;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/affinex_host.sv
// Bus initiator for the affine-transform peripheral: uploads coefficients,
// pushes points through the peripheral and streams the results out.
module affinex_host
    import affinex_pkg::*;
#(
    parameter int WAIT_CYCLES = 16,   // must be >= 1
    parameter int POLL_MAX    = 255   // must be >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_a,
    input  logic [15:0] cfg_b,
    input  logic [15:0] cfg_d,
    input  logic [15:0] cfg_e,
    input  logic [15:0] cfg_tx,
    input  logic [15:0] cfg_ty,
    input  logic        cfg_load,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_x,
    output logic [15:0] res_y,
    output logic        err,
    output logic        busy,
    output logic [5:0]  address,
    output logic [31:0] wdata,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] rdata,
    input  logic        data_ready
);

    host_state_t state, state_next;

    logic [15:0] coef_a, coef_b, coef_d, coef_e, coef_tx, coef_ty;
    logic [15:0] coef_sel;
    logic        cfg_pending, cfg_pending_next, cfg_clear;
    logic [2:0]  cfg_idx;
    logic [15:0] pt_x, pt_y;
    logic [15:0] wait_cnt, poll_cnt;
    logic        poll_fail;
    logic        in_ready_q;
    logic        accept;

    logic        acc_req, acc_we, acc_done;
    logic [5:0]  acc_addr;
    logic [31:0] acc_wdata, acc_rdata;
    logic        unused_acc_rdata_hi;

    // A simultaneous cfg_load takes priority over a waiting point.
    assign in_ready = in_ready_q & ~cfg_load;
    assign accept   = in_valid & in_ready;
    assign unused_acc_rdata_hi = ^acc_rdata[31:16];

    affinex_bus_access u_bus (
        .clk          (clk),
        .rst          (rst),
        .req          (acc_req),
        .we           (acc_we),
        .addr         (acc_addr),
        .wdata        (acc_wdata),
        .done         (acc_done),
        .rdata        (acc_rdata),
        .address      (address),
        .bus_wdata    (wdata),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .bus_rdata    (rdata),
        .data_ready   (data_ready)
    );

    // Select the shadow coefficient for the current upload slot.
    always_comb begin
        coef_sel = 16'h0000;
        case (cfg_idx)
            3'd0:    coef_sel = coef_a;
            3'd1:    coef_sel = coef_b;
            3'd2:    coef_sel = coef_d;
            3'd3:    coef_sel = coef_e;
            3'd4:    coef_sel = coef_tx;
            3'd5:    coef_sel = coef_ty;
            default: coef_sel = 16'h0000;
        endcase
    end

    // Sequencing FSM: next state and the bus request for the current step.
    always_comb begin
        state_next = state;
        acc_req    = 1'b0;
        acc_we     = 1'b0;
        acc_addr   = ADDR_CTRL;
        acc_wdata  = 32'h0000_0000;
        cfg_clear  = 1'b0;
        poll_fail  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_pending) begin
                    state_next = CFG;
                end else if (accept) begin
                    state_next = WR_X;
                end else begin
                    state_next = IDLE;
                end
            end
            CFG: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = coef_addr(cfg_idx);
                acc_wdata = sext16(coef_sel);
                if (acc_done && (cfg_idx == 3'd5)) begin
                    cfg_clear  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = CFG;
                end
            end
            WR_X: begin
                acc_req    = 1'b1;
                acc_we     = 1'b1;
                acc_addr   = ADDR_XIN;
                acc_wdata  = sext16(pt_x);
                state_next = acc_done ? WR_Y : WR_X;
            end
            WR_Y: begin
                acc_req    = 1'b1;
                acc_we     = 1'b1;
                acc_addr   = ADDR_YIN;
                acc_wdata  = sext16(pt_y);
                state_next = acc_done ? GO : WR_Y;
            end
            GO: begin
                acc_req    = 1'b1;
                acc_we     = 1'b1;
                acc_addr   = ADDR_CTRL;
                acc_wdata  = 32'h0000_0001;
                state_next = acc_done ? WAIT : GO;
            end
            WAIT: begin
                state_next = (wait_cnt == 16'(WAIT_CYCLES - 1)) ? STOP : WAIT;
            end
            STOP: begin
                acc_req    = 1'b1;
                acc_we     = 1'b1;
                acc_addr   = ADDR_CTRL;
                acc_wdata  = 32'h0000_0000;
                state_next = acc_done ? POLL : STOP;
            end
            POLL: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_STAT;
                if (acc_done && acc_rdata[0]) begin
                    state_next = RD_X;
                end else if (acc_done && (poll_cnt == 16'(POLL_MAX - 1))) begin
                    poll_fail  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = POLL;
                end
            end
            RD_X: begin
                acc_req    = 1'b1;
                acc_addr   = ADDR_XOUT;
                state_next = acc_done ? RD_Y : RD_X;
            end
            RD_Y: begin
                acc_req    = 1'b1;
                acc_addr   = ADDR_YOUT;
                state_next = acc_done ? OUT : RD_Y;
            end
            OUT: begin
                state_next = res_ready ? IDLE : OUT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A new cfg_load always re-arms the upload, even if one is just finishing.
    always_comb begin
        if (cfg_load) begin
            cfg_pending_next = 1'b1;
        end else if (cfg_clear) begin
            cfg_pending_next = 1'b0;
        end else begin
            cfg_pending_next = cfg_pending;
        end
    end

    // State register, shadows, counters and registered stream/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            coef_a      <= 16'h0000;
            coef_b      <= 16'h0000;
            coef_d      <= 16'h0000;
            coef_e      <= 16'h0000;
            coef_tx     <= 16'h0000;
            coef_ty     <= 16'h0000;
            cfg_pending <= 1'b0;
            cfg_idx     <= 3'd0;
            pt_x        <= 16'h0000;
            pt_y        <= 16'h0000;
            wait_cnt    <= 16'h0000;
            poll_cnt    <= 16'h0000;
            err         <= 1'b0;
            res_x       <= 16'h0000;
            res_y       <= 16'h0000;
            res_valid   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cfg_pending <= cfg_pending_next;
            in_ready_q  <= (state_next == IDLE) && !cfg_pending_next;
            res_valid   <= (state_next == OUT);
            busy        <= (state_next != IDLE);

            if (cfg_load) begin
                coef_a  <= cfg_a;
                coef_b  <= cfg_b;
                coef_d  <= cfg_d;
                coef_e  <= cfg_e;
                coef_tx <= cfg_tx;
                coef_ty <= cfg_ty;
            end

            if ((state == IDLE) && !cfg_pending && accept) begin
                pt_x <= in_x;
                pt_y <= in_y;
            end

            if (state != CFG) begin
                cfg_idx <= 3'd0;
            end else if (acc_done) begin
                cfg_idx <= cfg_idx + 3'd1;
            end

            wait_cnt <= (state == WAIT) ? (wait_cnt + 16'd1) : 16'd0;

            if (state != POLL) begin
                poll_cnt <= 16'd0;
            end else if (acc_done) begin
                poll_cnt <= poll_cnt + 16'd1;
            end

            // A timeout in the same cycle as cfg_load still reports the error.
            if (poll_fail) begin
                err <= 1'b1;
            end else if (cfg_load) begin
                err <= 1'b0;
            end

            if ((state == RD_X) && acc_done) begin
                res_x <= acc_rdata[15:0];
            end
            if ((state == RD_Y) && acc_done) begin
                res_y <= acc_rdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_affinex_host.sv
// Bench for affinex_host: behavioural peripheral with variable data_ready
// delay, write-order scoreboard and result scoreboard against an affine model.
`timescale 1ns/1ps
module tb_affinex_host;

    localparam int WAIT_CYCLES = 16;
    localparam int POLL_MAX    = 255;

    localparam logic [5:0] R_CTRL = 6'h00, R_STAT = 6'h04, R_A = 6'h08, R_B = 6'h0C;
    localparam logic [5:0] R_D = 6'h10, R_E = 6'h14, R_TX = 6'h18, R_TY = 6'h1C;
    localparam logic [5:0] R_XIN = 6'h20, R_YIN = 6'h24, R_XOUT = 6'h28, R_YOUT = 6'h2C;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_a, cfg_b, cfg_d, cfg_e, cfg_tx, cfg_ty;
    logic        cfg_load, in_valid, in_ready, res_valid, res_ready, err, busy, data_ready;
    logic [15:0] in_x, in_y, res_x, res_y;
    logic [5:0]  address;
    logic [31:0] wdata, rdata;
    logic [1:0]  data_write_n, data_read_n;

    always #5 clk = ~clk;

    affinex_host #(.WAIT_CYCLES(WAIT_CYCLES), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst(rst),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_d(cfg_d), .cfg_e(cfg_e), .cfg_tx(cfg_tx), .cfg_ty(cfg_ty),
        .cfg_load(cfg_load), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
        .err(err), .busy(busy), .address(address), .wdata(wdata),
        .data_write_n(data_write_n), .data_read_n(data_read_n), .rdata(rdata), .data_ready(data_ready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // out = floor((c1*x + c2*y) / 256) + t, coefficients in Q8.8.
    function automatic logic [31:0] affine(input logic [15:0] c1, input logic [15:0] c2,
                                          input logic [15:0] t, input logic [15:0] x, input logic [15:0] y);
        longint p;
        p = longint'($signed(c1)) * longint'($signed(x)) + longint'($signed(c2)) * longint'($signed(y));
        p = p >>> 8;
        p = p + longint'($signed(t));
        return p[31:0];
    endfunction

    // Reference state
    logic [15:0] ca = 16'h0, cb = 16'h0, cd = 16'h0, ce = 16'h0, ctx = 16'h0, cty = 16'h0;
    logic [37:0] exp_wr[$];
    logic [31:0] exp_res[$];
    bit          expect_timeout = 1'b0;

    // Peripheral model state
    logic [31:0] pregs [0:15];
    int  dly_min = 0, dly_max = 0, cur_dly = 0, act_cnt = 0;
    int  stat_zero = 0, stat_reads = 0, cyc = 0, ctrl1_cyc = 0;
    bit  in_access = 1'b0, prev_done = 1'b0, unstable = 1'b0, strobe = 1'b0;
    logic [41:0] hold_bus;
    logic [37:0] wr_entry;
    logic [31:0] xo, yo;
    int  rr_mode = 1;

    initial for (int i = 0; i < 16; i++) pregs[i] = 32'h0;

    // Peripheral: decide completion for the coming edge, drive data_ready/rdata, check bus protocol.
    always @(negedge clk) begin
        cyc++;
        strobe = (data_write_n != 2'b11) || (data_read_n != 2'b11);
        if (rst) begin
            data_ready = 1'b0; in_access = 1'b0; prev_done = 1'b0; act_cnt = 0;
        end else if (strobe) begin
            if (!in_access) begin
                check("bus_gap", {63'd0, prev_done}, 64'd0);
                check("one_strobe", {60'd0, data_write_n, data_read_n} == 64'hB || {60'd0, data_write_n, data_read_n} == 64'hE, 64'd1);
                if (address == R_CTRL && data_write_n == 2'b10 && wdata == 32'h0)
                    check("ctrl_gap", ((cyc - ctrl1_cyc) >= WAIT_CYCLES) && ((cyc - ctrl1_cyc) <= WAIT_CYCLES + 4), 64'd1);
                hold_bus  = {address, wdata, data_write_n, data_read_n};
                unstable  = 1'b0;
                act_cnt   = 0;
                in_access = 1'b1;
                cur_dly   = $urandom_range(dly_max, dly_min);
            end else if ({address, wdata, data_write_n, data_read_n} !== hold_bus) begin
                unstable = 1'b1;
            end
            prev_done = 1'b0;
            if (act_cnt >= cur_dly) begin
                data_ready = 1'b1;
                in_access  = 1'b0;
                prev_done  = 1'b1;
                check("bus_hold", {63'd0, unstable}, 64'd0);
                if (data_write_n == 2'b10) begin
                    if (exp_wr.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL bus_write: got %0h at %0h expected no write", wdata, address);
                    end else begin
                        wr_entry = exp_wr.pop_front();
                        check("bus_write", {26'd0, address, wdata}, {26'd0, wr_entry});
                    end
                    pregs[address[5:2]] = wdata;
                    if (address == R_CTRL && wdata == 32'h1) begin
                        xo = affine(pregs[2][15:0], pregs[3][15:0], pregs[6][15:0], pregs[8][15:0], pregs[9][15:0]);
                        yo = affine(pregs[4][15:0], pregs[5][15:0], pregs[7][15:0], pregs[8][15:0], pregs[9][15:0]);
                        pregs[10] = xo; pregs[11] = yo;
                        stat_reads = 0;
                        ctrl1_cyc  = cyc;
                    end
                end else begin
                    if (address == R_STAT) begin
                        rdata = (stat_zero < 0 || stat_reads < stat_zero) ? 32'h0 : 32'h1;
                        stat_reads++;
                    end else begin
                        rdata = pregs[address[5:2]];
                    end
                end
            end else begin
                data_ready = 1'b0;
                act_cnt++;
            end
        end else begin
            data_ready = 1'b0;
            prev_done  = 1'b0;
        end
    end

    logic [31:0] res_hold;
    logic [31:0] res_exp;
    bit          stalled = 1'b0;

    // Scoreboard: record accepted points, compare every delivered result.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_wr.push_back({R_XIN, sx(in_x)});
                exp_wr.push_back({R_YIN, sx(in_y)});
                exp_wr.push_back({R_CTRL, 32'h1});
                exp_wr.push_back({R_CTRL, 32'h0});
                if (!expect_timeout) begin
                    xo = affine(ca, cb, ctx, in_x, in_y);
                    yo = affine(cd, ce, cty, in_x, in_y);
                    exp_res.push_back({xo[15:0], yo[15:0]});
                end
            end
            if (stalled) begin
                check("res_hold_valid", {63'd0, res_valid}, 64'd1);
                check("res_hold_data", {32'd0, res_x, res_y}, {32'd0, res_hold});
            end
            stalled = 1'b0;
            if (res_valid) begin
                check("in_ready_during_out", {63'd0, in_ready}, 64'd0);
                if (res_ready) begin
                    if (exp_res.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL result: got %0h/%0h expected no result", res_x, res_y);
                    end else begin
                        res_exp = exp_res.pop_front();
                        check("result", {32'd0, res_x, res_y}, {32'd0, res_exp});
                    end
                end else begin
                    stalled  = 1'b1;
                    res_hold = {res_x, res_y};
                end
            end
        end
    end

    // Consumer: random, always-ready or stalled.
    always @(posedge clk) begin
        #1;
        res_ready = (rr_mode == 0) ? 1'($urandom_range(1, 0)) : (rr_mode == 1);
    end

    task automatic do_cfg(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d,
                          input logic [15:0] e, input logic [15:0] tx, input logic [15:0] ty);
        @(posedge clk); #1;
        cfg_a = a; cfg_b = b; cfg_d = d; cfg_e = e; cfg_tx = tx; cfg_ty = ty; cfg_load = 1'b1;
        ca = a; cb = b; cd = d; ce = e; ctx = tx; cty = ty;
        exp_wr.push_back({R_A, sx(a)});   exp_wr.push_back({R_B, sx(b)});
        exp_wr.push_back({R_D, sx(d)});   exp_wr.push_back({R_E, sx(e)});
        exp_wr.push_back({R_TX, sx(tx)}); exp_wr.push_back({R_TY, sx(ty)});
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic send_point(input logic [15:0] x, input logic [15:0] y);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_x = x; in_y = y;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 5000);
        check("accept_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end
        while ((busy || res_valid || exp_res.size() != 0 || exp_wr.size() != 0) && n < 5000);
        check("drain_results", exp_res.size(), 64'd0);
        check("drain_writes", exp_wr.size(), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_x = 16'h0; in_y = 16'h0;
        cfg_a = 16'h0; cfg_b = 16'h0; cfg_d = 16'h0; cfg_e = 16'h0; cfg_tx = 16'h0; cfg_ty = 16'h0;
        data_ready = 1'b0; rdata = 32'h0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_xy", {32'd0, res_x, res_y}, 64'd0);
        check("rst_err_busy", {62'd0, err, busy}, 64'd0);
        check("rst_bus", {20'd0, address, wdata, data_write_n, data_read_n}, {20'd0, 6'h0, 32'h0, 4'hF});
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed upload and first point, immediate data_ready
        dly_min = 0; dly_max = 0; stat_zero = 0;
        do_cfg(16'd256, 16'd0, 16'd0, 16'd256, 16'd10, 16'hFFFB);
        send_point(16'd3, 16'd4);
        drain();
        check("stat_reads_one", stat_reads, 64'd1);

        // Same point with data_ready held low 5 cycles per access
        dly_min = 5; dly_max = 5;
        send_point(16'd3, 16'd4);
        drain();

        // Consumer stall for 10 cycles
        dly_min = 0; dly_max = 1; rr_mode = 2;
        send_point(16'hFFF0, 16'd7);
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 2000);
        check("stall_res_valid", {63'd0, res_valid}, 64'd1);
        repeat (10) @(negedge clk);
        rr_mode = 1;
        drain();

        // Randomized coefficients, points, delays and back-pressure
        rr_mode = 0; dly_min = 0; dly_max = 3;
        for (int k = 0; k < 3; k++) begin
            do_cfg(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            for (int j = 0; j < 8; j++) begin
                stat_zero = $urandom_range(3, 0);
                send_point(16'($urandom), 16'($urandom));
            end
        end
        drain();

        // Poll timeout
        rr_mode = 1; dly_min = 0; dly_max = 2; stat_zero = -1; expect_timeout = 1'b1;
        send_point(16'd1, 16'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!err && n < 5000);
        check("timeout_err", {63'd0, err}, 64'd1);
        repeat (3) @(negedge clk);
        check("timeout_reads", stat_reads, POLL_MAX);
        check("timeout_idle", {62'd0, busy, res_valid}, 64'd0);
        drain();
        expect_timeout = 1'b0; stat_zero = 0;
        do_cfg(16'd128, 16'd64, 16'hFF00, 16'd512, 16'd100, 16'hFC18);
        @(negedge clk);
        check("err_cleared", {63'd0, err}, 64'd0);
        drain();

        // cfg_load while the current point is polling
        stat_zero = 20;
        send_point(16'd50, 16'hFFCE);
        n = 0;
        do begin @(negedge clk); n++; end while (stat_reads == 0 && n < 2000);
        do_cfg(16'd300, 16'hFFB0, 16'd20, 16'd200, 16'hFFF6, 16'd33);
        stat_zero = 0;
        send_point(16'd9, 16'd11);
        drain();

        // Asynchronous reset in the middle of a transaction
        dly_min = 6; dly_max = 6;
        send_point(16'd5, 16'd6);
        n = 0;
        do begin @(negedge clk); n++; end while (data_write_n == 2'b11 && data_read_n == 2'b11 && n < 2000);
        #2 rst = 1'b1;
        #1;
        check("async_rst_strobes", {60'd0, data_write_n, data_read_n}, 64'hF);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        exp_wr.delete(); exp_res.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_ready", {63'd0, in_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
